// File: rtl/cci_mpf_shim_edge_to_fiu.sv
// cci_mpf_shim_edge_to_fiu: strips MPF header extensions, buffers C0/C1 TX per channel and drops non-physical addresses
// Layouts (LSB first): c0 {rdValid, base[62:1], ext[70:63]}; c1 {intrValid, wrValid, data[513:2], base[576:514], ext[584:577]}; ext {addressExt[5:0], addrIsVirtual, checkLoadStoreOrder}
module cci_mpf_shim_edge_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 16,
  parameter int THRESH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         fiu_alm_full,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic         alm_full,
  output logic         overflow,
  output logic [W-1:0] out_data
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LIMIT = (AW+1)'(THRESH + 2);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count, count_next;
  logic enq, deq;
  always_comb begin
    overflow = push && count == FULL;
    enq = push && count != FULL;
    deq = count != '0 && !fiu_alm_full;
    count_next = count + (AW+1)'(enq) - (AW+1)'(deq);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      out_valid <= 1'b0;
      alm_full <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(enq);
      rd_ptr <= rd_ptr + AW'(deq);
      count <= count_next;
      out_valid <= deq;
      alm_full <= (FULL - count_next) <= LIMIT;
    end
  end
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= in_data;
    if (deq) out_data <= mem[rd_ptr];
  end
endmodule

module cci_mpf_shim_edge_to_fiu #(
  parameter int DEPTH = 16,
  parameter int ERR_CNT_WIDTH = 16,
  parameter int CCI_ALMOST_FULL_THRESHOLD = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [70:0]              afu_c0Tx,
  input  logic [584:0]             afu_c1Tx,
  output logic                     afu_c0TxAlmFull,
  output logic                     afu_c1TxAlmFull,
  output logic [62:0]              fiu_c0Tx,
  output logic [576:0]             fiu_c1Tx,
  input  logic                     fiu_c0TxAlmFull,
  input  logic                     fiu_c1TxAlmFull,
  output logic                     err_virt_addr,
  output logic                     err_overflow,
  output logic [ERR_CNT_WIDTH-1:0] virt_drop_cnt
);
  logic c0_bad, c1_bad, drop0, drop1, push0, push1, ovf0, ovf1, c0_valid, c1_valid;
  logic [61:0] c0_data;
  logic [576:0] c1_data;
  logic [ERR_CNT_WIDTH:0] cnt_sum;
  logic unused_lso;
  always_comb begin
    c0_bad = afu_c0Tx[69] || afu_c0Tx[68:63] != '0;
    c1_bad = afu_c1Tx[583] || afu_c1Tx[582:577] != '0;
    drop0 = afu_c0Tx[0] && c0_bad;
    drop1 = afu_c1Tx[1] && c1_bad;
    push0 = afu_c0Tx[0] && !c0_bad;
    push1 = (afu_c1Tx[1] || afu_c1Tx[0]) && !drop1;
    cnt_sum = {1'b0, virt_drop_cnt} + (ERR_CNT_WIDTH+1)'(drop0) + (ERR_CNT_WIDTH+1)'(drop1);
    unused_lso = afu_c0Tx[70] ^ afu_c1Tx[584];
  end
  cci_mpf_shim_edge_fifo #(.W(62), .DEPTH(DEPTH), .THRESH(CCI_ALMOST_FULL_THRESHOLD)) u_c0 (
    .clk(clk), .reset(reset), .push(push0), .fiu_alm_full(fiu_c0TxAlmFull), .in_data(afu_c0Tx[62:1]),
    .out_valid(c0_valid), .alm_full(afu_c0TxAlmFull), .overflow(ovf0), .out_data(c0_data)
  );
  cci_mpf_shim_edge_fifo #(.W(577), .DEPTH(DEPTH), .THRESH(CCI_ALMOST_FULL_THRESHOLD)) u_c1 (
    .clk(clk), .reset(reset), .push(push1), .fiu_alm_full(fiu_c1TxAlmFull), .in_data(afu_c1Tx[576:0]),
    .out_valid(c1_valid), .alm_full(afu_c1TxAlmFull), .overflow(ovf1), .out_data(c1_data)
  );
  // Stale head data is harmless, but the valid bits must be masked when nothing was popped
  assign fiu_c0Tx = {c0_data, c0_valid};
  assign fiu_c1Tx = {c1_data[576:2], c1_data[1] & c1_valid, c1_data[0] & c1_valid};
  always_ff @(posedge clk) begin
    if (reset) begin
      err_virt_addr <= 1'b0;
      err_overflow <= 1'b0;
      virt_drop_cnt <= '0;
    end else begin
      err_virt_addr <= err_virt_addr | drop0 | drop1;
      err_overflow <= err_overflow | ovf0 | ovf1;
      virt_drop_cnt <= cnt_sum[ERR_CNT_WIDTH] ? '1 : cnt_sum[ERR_CNT_WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_cci_mpf_shim_edge_to_fiu.sv
// tb_cci_mpf_shim_edge_to_fiu: directed scenarios plus randomized traffic against a queue-based reference model
module tb_cci_mpf_shim_edge_to_fiu;
  localparam int DEPTH = 16, THR = 8;
  logic clk = 0, reset = 1;
  logic [70:0] afu_c0Tx = '0;
  logic [584:0] afu_c1Tx = '0;
  logic fiu_c0TxAlmFull = 0, fiu_c1TxAlmFull = 0;
  logic afu_c0TxAlmFull, afu_c1TxAlmFull, err_virt_addr, err_overflow;
  logic [62:0] fiu_c0Tx;
  logic [576:0] fiu_c1Tx;
  logic [15:0] virt_drop_cnt;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  cci_mpf_shim_edge_to_fiu #(.DEPTH(DEPTH), .ERR_CNT_WIDTH(16), .CCI_ALMOST_FULL_THRESHOLD(THR)) dut (
    .clk(clk), .reset(reset), .afu_c0Tx(afu_c0Tx), .afu_c1Tx(afu_c1Tx),
    .afu_c0TxAlmFull(afu_c0TxAlmFull), .afu_c1TxAlmFull(afu_c1TxAlmFull),
    .fiu_c0Tx(fiu_c0Tx), .fiu_c1Tx(fiu_c1Tx),
    .fiu_c0TxAlmFull(fiu_c0TxAlmFull), .fiu_c1TxAlmFull(fiu_c1TxAlmFull),
    .err_virt_addr(err_virt_addr), .err_overflow(err_overflow), .virt_drop_cnt(virt_drop_cnt)
  );

  function automatic logic [70:0] mk_c0(input logic [61:0] b, input logic v, input logic [5:0] e, input logic lso, input logic rv);
    return {lso, v, e, b, rv};
  endfunction
  function automatic logic [584:0] mk_c1(input logic [62:0] b, input logic [511:0] d, input logic v, input logic [5:0] e,
                                         input logic lso, input logic wr, input logic intr);
    return {lso, v, e, b, d, wr, intr};
  endfunction
  function automatic logic [61:0] rb0();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[61:0];
  endfunction
  function automatic logic [62:0] rb1();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[62:0];
  endfunction
  function automatic logic [511:0] rdat();
    logic [511:0] t;
    for (int i = 0; i < 16; i++) t[i*32 +: 32] = $urandom();
    return t;
  endfunction

  // Reference model: each channel is a plain queue of accepted entries
  logic [61:0] q0[$];
  logic [576:0] q1[$];
  logic ev0, ev1, ealm0, ealm1, eerr_v, eerr_o;
  logic [61:0] ed0;
  logic [576:0] ed1;
  int ecnt, s0, s1, nd;
  always @(posedge clk) begin
    if (reset) begin
      q0.delete(); q1.delete();
      ev0 = 0; ev1 = 0; ealm0 = 0; ealm1 = 0; eerr_v = 0; eerr_o = 0; ecnt = 0;
    end else begin
      s0 = q0.size(); s1 = q1.size(); nd = 0;
      ev0 = s0 > 0 && !fiu_c0TxAlmFull;
      if (ev0) ed0 = q0.pop_front();
      ev1 = s1 > 0 && !fiu_c1TxAlmFull;
      if (ev1) ed1 = q1.pop_front();
      if (afu_c0Tx[0]) begin
        if (afu_c0Tx[69] || afu_c0Tx[68:63] != 0) begin nd++; eerr_v = 1; end
        else if (s0 >= DEPTH) eerr_o = 1;
        else q0.push_back(afu_c0Tx[62:1]);
      end
      if (afu_c1Tx[1] || afu_c1Tx[0]) begin
        if (afu_c1Tx[1] && (afu_c1Tx[583] || afu_c1Tx[582:577] != 0)) begin nd++; eerr_v = 1; end
        else if (s1 >= DEPTH) eerr_o = 1;
        else q1.push_back(afu_c1Tx[576:0]);
      end
      ecnt = (ecnt + nd > 65535) ? 65535 : ecnt + nd;
      ealm0 = (DEPTH - q0.size()) <= THR + 2;
      ealm1 = (DEPTH - q1.size()) <= THR + 2;
    end
  end

  task automatic do_reset();
    afu_c0Tx = '0; afu_c1Tx = '0; fiu_c0TxAlmFull = 0; fiu_c1TxAlmFull = 0;
    reset = 1;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    checks++; if (fiu_c0Tx[0] !== 1'b0 || fiu_c1Tx[1:0] !== 2'b00) begin errors++; $display("FAIL reset_valid c0=%b c1=%b want 0", fiu_c0Tx[0], fiu_c1Tx[1:0]); end
    checks++; if ({afu_c0TxAlmFull, afu_c1TxAlmFull} !== 2'b00) begin errors++; $display("FAIL reset_almfull got=%b want 00", {afu_c0TxAlmFull, afu_c1TxAlmFull}); end
    checks++; if ({err_virt_addr, err_overflow} !== 2'b00 || virt_drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_err flags=%b cnt=%0d want 0", {err_virt_addr, err_overflow}, virt_drop_cnt); end
  endtask

  task automatic test_single_read();
    afu_c0Tx = mk_c0({4'h3, 42'h1234, 16'h5}, 0, 0, 0, 1);
    @(negedge clk); afu_c0Tx = '0;
    checks++; if (fiu_c0Tx[0] !== 1'b0) begin errors++; $display("FAIL single_early rdValid=%b want 0", fiu_c0Tx[0]); end
    @(negedge clk);
    checks++; if (fiu_c0Tx[0] !== 1'b1 || fiu_c0Tx[58:17] !== 42'h1234 || fiu_c0Tx[16:1] !== 16'h5)
      begin errors++; $display("FAIL single_read got=%h want valid addr 1234 mdata 5", fiu_c0Tx); end
    @(negedge clk);
    checks++; if (fiu_c0Tx[0] !== 1'b0) begin errors++; $display("FAIL single_once rdValid=%b want 0", fiu_c0Tx[0]); end
    checks++; if ({err_virt_addr, err_overflow} !== 2'b00) begin errors++; $display("FAIL single_err flags=%b want 00", {err_virt_addr, err_overflow}); end
  endtask

  task automatic test_virt_drop();
    int seen = 0;
    logic [62:0] b;
    logic [511:0] d;
    afu_c1Tx = mk_c1(rb1(), rdat(), 1, 0, 0, 1, 0);
    @(negedge clk); afu_c1Tx = '0;
    afu_c0Tx = mk_c0(rb0(), 0, 6'h1, 0, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); afu_c0Tx = '0;
      if (fiu_c0Tx[0] || fiu_c1Tx[1] || fiu_c1Tx[0]) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL virt_leak got=%0d outputs want 0", seen); end
    checks++; if (err_virt_addr !== 1'b1 || err_overflow !== 1'b0) begin errors++; $display("FAIL virt_flags got=%b want 10", {err_virt_addr, err_overflow}); end
    checks++; if (virt_drop_cnt !== 16'd2) begin errors++; $display("FAIL virt_cnt got=%0d want 2", virt_drop_cnt); end
    b = rb1(); d = rdat();
    afu_c1Tx = mk_c1(b, d, 0, 0, 1, 1, 0);
    @(negedge clk); afu_c1Tx = '0;
    @(negedge clk);
    checks++; if (fiu_c1Tx !== {b, d, 2'b10}) begin errors++; $display("FAIL virt_good_write got=%h want=%h", fiu_c1Tx, {b, d, 2'b10}); end
    afu_c0Tx = mk_c0(rb0(), 1, 0, 0, 1);
    afu_c1Tx = mk_c1(rb1(), rdat(), 0, 6'h20, 0, 1, 0);
    @(negedge clk); afu_c0Tx = '0; afu_c1Tx = '0;
    checks++; if (virt_drop_cnt !== 16'd4) begin errors++; $display("FAIL virt_dual_cnt got=%0d want 4", virt_drop_cnt); end
  endtask

  task automatic test_fill();
    logic [576:0] exp_q[$];
    logic [576:0] e;
    int n;
    do_reset();
    fiu_c1TxAlmFull = 1;
    for (int k = 1; k <= DEPTH + 1; k++) begin
      afu_c1Tx = mk_c1(rb1(), rdat(), 0, 0, 0, 1, 0);
      if (k <= DEPTH) exp_q.push_back(afu_c1Tx[576:0]);
      @(negedge clk);
      n = (k > DEPTH) ? DEPTH : k;
      checks++; if (afu_c1TxAlmFull !== ((DEPTH - n) <= THR + 2)) begin errors++; $display("FAIL fill_almfull k=%0d got=%b want=%b", k, afu_c1TxAlmFull, (DEPTH - n) <= THR + 2); end
      checks++; if (err_overflow !== (k == DEPTH + 1)) begin errors++; $display("FAIL fill_overflow k=%0d got=%b want=%b", k, err_overflow, k == DEPTH + 1); end
    end
    afu_c1Tx = '0;
    fiu_c1TxAlmFull = 0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (fiu_c1Tx !== e) begin errors++; $display("FAIL fill_drain i=%0d got=%h want=%h", i, fiu_c1Tx, e); end
    end
    @(negedge clk);
    checks++; if (fiu_c1Tx[1:0] !== 2'b00 || afu_c1TxAlmFull !== 1'b0) begin errors++; $display("FAIL fill_empty valid=%b almfull=%b want 0", fiu_c1Tx[1:0], afu_c1TxAlmFull); end
  endtask

  task automatic test_independent();
    logic [61:0] e0[$], g0[$];
    logic [576:0] e1[$], g1[$];
    int early = 0;
    do_reset();
    fiu_c0TxAlmFull = 1;
    for (int c = 0; c < 30; c++) begin
      if (c < 8) begin
        afu_c0Tx = mk_c0(rb0(), 0, 0, 1'($urandom), 1); e0.push_back(afu_c0Tx[62:1]);
        afu_c1Tx = mk_c1(rb1(), rdat(), 0, 0, 0, 1, 0); e1.push_back(afu_c1Tx[576:0]);
      end else begin
        afu_c0Tx = '0; afu_c1Tx = '0;
      end
      if (c == 16) fiu_c0TxAlmFull = 0;
      @(negedge clk);
      if (fiu_c1Tx[1]) g1.push_back(fiu_c1Tx);
      if (fiu_c0Tx[0]) begin if (c < 16) early++; g0.push_back(fiu_c0Tx[62:1]); end
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL indep_c0_stall got=%0d early outputs want 0", early); end
    checks++; if (g1.size() !== 8 || g1 != e1) begin errors++; $display("FAIL indep_c1 got=%0d entries (order/data differ) want 8 in order", g1.size()); end
    checks++; if (g0.size() !== 8 || g0 != e0) begin errors++; $display("FAIL indep_c0 got=%0d entries (order/data differ) want 8 in order", g0.size()); end
  endtask

  task automatic test_intr();
    logic [62:0] b;
    logic [511:0] d;
    do_reset();
    b = rb1(); d = rdat();
    afu_c1Tx = mk_c1(b, d, 1, 6'h3f, 0, 0, 1);
    @(negedge clk); afu_c1Tx = '0;
    @(negedge clk);
    checks++; if (fiu_c1Tx !== {b, d, 2'b01}) begin errors++; $display("FAIL intr_pass got=%h want=%h", fiu_c1Tx, {b, d, 2'b01}); end
    checks++; if (err_virt_addr !== 1'b0 || virt_drop_cnt !== 16'd0) begin errors++; $display("FAIL intr_err flag=%b cnt=%0d want 0", err_virt_addr, virt_drop_cnt); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    do_reset();
    fiu_c0TxAlmFull = 1;
    afu_c1Tx = mk_c1(rb1(), rdat(), 1, 0, 0, 1, 0);
    for (int i = 0; i < 7; i++) begin
      afu_c0Tx = mk_c0(rb0(), 0, 0, 0, 1);
      @(negedge clk); afu_c1Tx = '0;
    end
    afu_c0Tx = '0;
    checks++; if (afu_c0TxAlmFull !== 1'b1 || err_virt_addr !== 1'b1) begin errors++; $display("FAIL midrst_pre almfull=%b err=%b want 11", afu_c0TxAlmFull, err_virt_addr); end
    reset = 1;
    @(negedge clk);
    reset = 0; fiu_c0TxAlmFull = 0;
    checks++; if ({afu_c0TxAlmFull, err_virt_addr, err_overflow} !== 3'b000 || virt_drop_cnt !== 16'd0)
      begin errors++; $display("FAIL midrst_state almfull/flags=%b cnt=%0d want 0", {afu_c0TxAlmFull, err_virt_addr, err_overflow}, virt_drop_cnt); end
    for (int i = 0; i < 5; i++) begin
      if (fiu_c0Tx[0]) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_flush got=%0d outputs want 0", seen); end
    afu_c0Tx = mk_c0({4'h1, 42'h2aa55, 16'h77}, 0, 0, 0, 1);
    @(negedge clk); afu_c0Tx = '0;
    checks++; if (fiu_c0Tx[0] !== 1'b0) begin errors++; $display("FAIL midrst_early rdValid=%b want 0", fiu_c0Tx[0]); end
    @(negedge clk);
    checks++; if (fiu_c0Tx !== {4'h1, 42'h2aa55, 16'h77, 1'b1}) begin errors++; $display("FAIL midrst_read got=%h want=%h", fiu_c0Tx, {4'h1, 42'h2aa55, 16'h77, 1'b1}); end
  endtask

  task automatic test_random();
    logic v;
    logic [5:0] e;
    int k;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      checks++; if (fiu_c0Tx[0] !== ev0 || (ev0 && fiu_c0Tx[62:1] !== ed0)) begin errors++; $display("FAIL rand_c0 cyc=%0d got=%h want valid=%b data=%h", c, fiu_c0Tx, ev0, ed0); end
      checks++; if (fiu_c1Tx[1:0] !== (ev1 ? ed1[1:0] : 2'b00) || (ev1 && fiu_c1Tx !== ed1)) begin errors++; $display("FAIL rand_c1 cyc=%0d got=%h want valid=%b data=%h", c, fiu_c1Tx, ev1, ed1); end
      checks++; if ({afu_c0TxAlmFull, afu_c1TxAlmFull} !== {ealm0, ealm1}) begin errors++; $display("FAIL rand_almfull cyc=%0d got=%b want=%b", c, {afu_c0TxAlmFull, afu_c1TxAlmFull}, {ealm0, ealm1}); end
      checks++; if ({err_virt_addr, err_overflow} !== {eerr_v, eerr_o}) begin errors++; $display("FAIL rand_flags cyc=%0d got=%b want=%b", c, {err_virt_addr, err_overflow}, {eerr_v, eerr_o}); end
      checks++; if (virt_drop_cnt !== 16'(ecnt)) begin errors++; $display("FAIL rand_cnt cyc=%0d got=%0d want=%0d", c, virt_drop_cnt, ecnt); end
      fiu_c0TxAlmFull = $urandom_range(0, 9) < (((c / 150) % 2) ? 9 : 2);
      fiu_c1TxAlmFull = $urandom_range(0, 9) < ((((c + 75) / 150) % 2) ? 9 : 2);
      v = 0; e = 0;
      if ($urandom_range(0, 6) == 0) begin if ($urandom_range(0, 1) == 1) v = 1; else e = 6'($urandom_range(1, 63)); end
      afu_c0Tx = mk_c0(rb0(), v, e, 1'($urandom), $urandom_range(0, 9) < 7);
      v = 0; e = 0;
      if ($urandom_range(0, 6) == 0) begin if ($urandom_range(0, 1) == 1) v = 1; else e = 6'($urandom_range(1, 63)); end
      k = $urandom_range(0, 5);
      afu_c1Tx = mk_c1(rb1(), rdat(), v, e, 1'($urandom), k == 1 || k == 2 || k == 4, k == 3 || k == 4);
      @(negedge clk);
    end
    afu_c0Tx = '0; afu_c1Tx = '0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 0;
    test_reset();
    test_single_read();
    test_virt_drop();
    test_fill();
    test_independent();
    test_intr();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
